// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-sequencing memory controller: state
// encodings, access-length codes and the constants used across the pipeline.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IF_RD  = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_MEM_WR = 2'd3
  } state_t;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd3;

  localparam int RAM_DATA_W = 8;

  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  localparam logic        ENABLE    = 1'b1;
  localparam logic        DISABLE   = 1'b0;

  // Byte count for a mem_len code; the unused code 2 is treated as a word.
  function automatic logic [2:0] len_to_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Single-port memory controller/arbiter. Shares one byte-wide synchronous RAM
// between instruction fetch and load/store, splitting each access into
// consecutive byte cycles and assembling read data little-endian.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req,
  input  logic [ADDR_W-1:0]     if_addr,
  output logic                  if_done,
  output logic [DATA_W-1:0]     if_data,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_len,
  input  logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_done,
  output logic [DATA_W-1:0]     mem_rdata,
  output logic                  stall_o,
  output logic [ADDR_W-1:0]     ram_a,
  output logic [RAM_DATA_W-1:0] ram_dout,
  output logic                  ram_wr,
  input  logic [RAM_DATA_W-1:0] ram_din
);

  state_t                  state_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [DATA_W-1:0]       wdata_reg;
  logic [2:0]              n_reg;
  logic [2:0]              i_reg;
  logic [DATA_W-1:0]       asm_reg;
  logic [DATA_W-1:0]       asm_next;

  logic [ADDR_W-1:0]       ram_a_reg;
  logic [RAM_DATA_W-1:0]   ram_dout_reg;
  logic                    ram_wr_reg;
  logic                    if_done_reg;
  logic [DATA_W-1:0]       if_data_reg;
  logic                    mem_done_reg;
  logic [DATA_W-1:0]       mem_rdata_reg;

  // i counts byte cycles since the state was entered; the byte on ram_din
  // belongs to the address issued one cycle earlier, hence cap_idx = i - 1.
  logic [2:0]              i_inc;
  logic [1:0]              cap_idx;
  logic [1:0]              nxt_idx;
  logic [ADDR_W-1:0]       addr_nxt;

  assign i_inc    = i_reg + 3'd1;
  assign cap_idx  = i_reg[1:0] - 2'd1;
  assign nxt_idx  = i_reg[1:0] + 2'd1;
  assign addr_nxt = addr_reg + ADDR_W'(i_inc);

  assign ram_a     = ram_a_reg;
  assign ram_dout  = ram_dout_reg;
  assign ram_wr    = ram_wr_reg & rdy;
  assign if_done   = if_done_reg;
  assign if_data   = if_data_reg;
  assign mem_done  = mem_done_reg;
  assign mem_rdata = mem_rdata_reg;
  assign stall_o   = mem_req & ~mem_done_reg;

  // Merge the byte currently on ram_din into the assembly buffer.
  always_comb begin
    asm_next = asm_reg;
    if (i_reg != 3'd0) begin
      asm_next[{cap_idx, 3'b000} +: RAM_DATA_W] = ram_din;
    end
  end

  // Arbitration, byte sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      wdata_reg     <= ZERO_WORD;
      n_reg         <= 3'd0;
      i_reg         <= 3'd0;
      asm_reg       <= ZERO_WORD;
      ram_a_reg     <= '0;
      ram_dout_reg  <= '0;
      ram_wr_reg    <= DISABLE;
      if_done_reg   <= DISABLE;
      if_data_reg   <= ZERO_WORD;
      mem_done_reg  <= DISABLE;
      mem_rdata_reg <= ZERO_WORD;
    end else if (rdy) begin
      if_done_reg  <= DISABLE;
      mem_done_reg <= DISABLE;
      case (state_reg)
        ST_IDLE: begin
          // A port whose done is still high is not re-accepted.
          if (mem_req && !mem_done_reg) begin
            addr_reg  <= mem_addr;
            wdata_reg <= mem_wdata;
            n_reg     <= len_to_bytes(mem_len);
            i_reg     <= 3'd0;
            asm_reg   <= ZERO_WORD;
            ram_a_reg <= mem_addr;
            if (mem_we) begin
              state_reg    <= ST_MEM_WR;
              ram_dout_reg <= mem_wdata[RAM_DATA_W-1:0];
              ram_wr_reg   <= ENABLE;
            end else begin
              state_reg <= ST_MEM_RD;
            end
          end else if (if_req && !if_done_reg) begin
            addr_reg  <= if_addr;
            n_reg     <= 3'd4;
            i_reg     <= 3'd0;
            asm_reg   <= ZERO_WORD;
            ram_a_reg <= if_addr;
            state_reg <= ST_IF_RD;
          end
        end

        ST_IF_RD, ST_MEM_RD: begin
          if (state_reg == ST_IF_RD && !if_req) begin
            // Fetch flushed by the pipeline: drop it silently.
            state_reg <= ST_IDLE;
            i_reg     <= 3'd0;
            asm_reg   <= ZERO_WORD;
            ram_a_reg <= '0;
          end else begin
            asm_reg <= asm_next;
            if (i_reg == n_reg) begin
              state_reg <= ST_IDLE;
              i_reg     <= 3'd0;
              ram_a_reg <= '0;
              if (state_reg == ST_IF_RD) begin
                if_done_reg <= ENABLE;
                if_data_reg <= asm_next;
              end else begin
                mem_done_reg  <= ENABLE;
                mem_rdata_reg <= asm_next;
              end
            end else begin
              i_reg     <= i_inc;
              ram_a_reg <= (i_inc < n_reg) ? addr_nxt : '0;
            end
          end
        end

        ST_MEM_WR: begin
          if (i_inc == n_reg) begin
            state_reg    <= ST_IDLE;
            i_reg        <= 3'd0;
            ram_a_reg    <= '0;
            ram_dout_reg <= '0;
            ram_wr_reg   <= DISABLE;
            mem_done_reg <= ENABLE;
          end else begin
            i_reg        <= i_inc;
            ram_a_reg    <= addr_nxt;
            ram_dout_reg <= wdata_reg[{nxt_idx, 3'b000} +: RAM_DATA_W];
          end
        end

        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a table of single transactions plus
// hand-written sequences for contention, flush, rdy stall and mid-load reset.
module tb_mem_ctrl;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [DATA_W-1:0] if_data;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_len;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_done;
  logic [DATA_W-1:0] mem_rdata;
  logic              stall_o;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  always #5 clk = ~clk;

  mem_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_data(if_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_len(mem_len), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .stall_o(stall_o), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr),
    .ram_din(ram_din)
  );

  // Byte-wide synchronous RAM, 4 KiB aliased on the low address bits.
  logic [7:0]  ram [0:4095];
  logic        pre_we;
  logic [11:0] pre_a;
  logic [7:0]  pre_d;

  always @(posedge clk) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (ram_wr) ram[ram_a[11:0]] <= ram_dout;
    ram_din <= ram[ram_a[11:0]];
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] d);
    pre_we = 1'b1;
    pre_a  = a;
    pre_d  = d;
    step();
    pre_we = 1'b0;
  endtask

  typedef struct {
    logic        port_mem;
    logic        we;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_n;
    int          exp_lat;
  } vec_t;

  vec_t vecs [12];

  // Issue one request in the current cycle, follow it to done, check it.
  task automatic run_txn(input logic port_mem, input logic we, input logic [1:0] len,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input int exp_n,
                         input int exp_lat, input int id);
    int          lat;
    int          wr_cnt;
    logic        got;
    logic [31:0] data;
    logic [31:0] a_seen [4];
    logic [7:0]  d_seen [4];
    if (port_mem) begin
      mem_we = we; mem_len = len; mem_addr = addr; mem_wdata = wdata; mem_req = 1'b1;
    end else begin
      if_addr = addr; if_req = 1'b1;
    end
    lat = 0; wr_cnt = 0; got = 1'b0; data = '0;
    for (int k = 0; k < 4; k++) begin a_seen[k] = '0; d_seen[k] = '0; end
    while (!got && lat < 40) begin
      step();
      lat++;
      if (lat <= 4) begin
        a_seen[lat-1] = ram_a;
        d_seen[lat-1] = ram_dout;
      end
      if (ram_wr) wr_cnt++;
      if (port_mem ? mem_done : if_done) begin
        got = 1'b1;
        data = port_mem ? mem_rdata : if_data;
      end
    end
    mem_req = 1'b0;
    if_req  = 1'b0;
    $display("txn %0d: %s %s addr=0x%08h data=0x%08h lat=%0d writes=%0d",
             id, port_mem ? "MEM" : "IF", we ? "wr" : "rd", addr, data, lat, wr_cnt);
    chk($sformatf("v%0d_latency", id), 32'(lat), 32'(exp_lat));
    chk($sformatf("v%0d_wr_count", id), 32'(wr_cnt), we ? 32'(exp_n) : 32'd0);
    if (!we) chk($sformatf("v%0d_rdata", id), data, exp_data);
    for (int k = 0; k < exp_n; k++) begin
      chk($sformatf("v%0d_ram_a%0d", id, k), a_seen[k], addr + 32'(k));
      chk($sformatf("v%0d_ram_dout%0d", id, k), {24'h0, d_seen[k]},
          we ? {24'h0, wdata[8*k +: 8]} : 32'h0);
    end
    step();
  endtask

  int   lat;
  int   wr_cnt;
  logic got;
  logic flag;

  initial begin
    rst = 1'b1; rdy = 1'b1; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
    mem_len = 2'd0; mem_addr = '0; mem_wdata = '0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    step(); step();

    // Reset state
    chk("rst_ram_a", ram_a, 32'h0);
    chk("rst_ram_dout", {24'h0, ram_dout}, 32'h0);
    chk("rst_ram_wr", {31'h0, ram_wr}, 32'h0);
    chk("rst_if_done", {31'h0, if_done}, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_mem_done", {31'h0, mem_done}, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_stall", {31'h0, stall_o}, 32'h0);
    rst = 1'b0;
    step();

    preload(12'h100, 8'h13); preload(12'h101, 8'h05);
    preload(12'h102, 8'h10); preload(12'h103, 8'h00);
    preload(12'h200, 8'hEF); preload(12'h201, 8'hBE);
    preload(12'h202, 8'hAD); preload(12'h203, 8'hDE);
    preload(12'hFFE, 8'h78); preload(12'hFFF, 8'h34);
    preload(12'h000, 8'h12); preload(12'h001, 8'h56);
    preload(12'h020, 8'h00); preload(12'h021, 8'h5A);
    for (int k = 0; k < 4; k++) begin
      preload(12'h300 + 12'(k), 8'h00);
      preload(12'h400 + 12'(k), 8'h00);
      preload(12'h500 + 12'(k), 8'h00);
    end

    //            mem   we    len    addr          wdata         exp_data      n  lat
    vecs[0]  = '{1'b0, 1'b0, 2'd3, 32'h0000_0100, 32'h0,        32'h0010_0513, 4, 6};
    vecs[1]  = '{1'b1, 1'b1, 2'd0, 32'h0000_0020, 32'hAABB_CCDD, 32'h0,        1, 2};
    vecs[2]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0020, 32'h0,        32'h0000_5ADD, 2, 4};
    vecs[3]  = '{1'b1, 1'b0, 2'd1, 32'hFFFF_FFFF, 32'h0,        32'h0000_1234, 2, 4};
    vecs[4]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 4, 6};
    vecs[5]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0200, 32'h0,        32'hDEAD_BEEF, 4, 6};
    vecs[6]  = '{1'b1, 1'b1, 2'd3, 32'h0000_0300, 32'h1122_3344, 32'h0,        4, 5};
    vecs[7]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0300, 32'h0,        32'h1122_3344, 4, 6};
    vecs[8]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0400, 32'hCAFE_BABE, 32'h0,        2, 3};
    vecs[9]  = '{1'b1, 1'b0, 2'd3, 32'h0000_0400, 32'h0,        32'h0000_BABE, 4, 6};
    vecs[10] = '{1'b1, 1'b0, 2'd0, 32'h0000_0201, 32'h0,        32'h0000_00BE, 1, 3};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 32'hFFFF_FFFE, 32'h0,        32'h5612_3478, 4, 6};

    for (int v = 0; v < 12; v++) begin
      run_txn(vecs[v].port_mem, vecs[v].we, vecs[v].len, vecs[v].addr, vecs[v].wdata,
              vecs[v].exp_data, vecs[v].exp_n, vecs[v].exp_lat, v);
    end

    // Contention: both ports request together, MEM must go first.
    mem_we = 1'b0; mem_len = 2'd3; mem_addr = 32'h200; if_addr = 32'h100;
    mem_req = 1'b1; if_req = 1'b1;
    #1;
    chk("cont_stall_start", {31'h0, stall_o}, 32'h1);
    lat = 0; got = 1'b0; flag = 1'b0;
    while (!got && lat < 40) begin
      step();
      lat++;
      if (if_done) flag = 1'b1;
      if (mem_done) got = 1'b1;
      else if (stall_o !== 1'b1) flag = 1'b1;
    end
    $display("contention: mem_done after %0d cycles, mem_rdata=0x%08h", lat, mem_rdata);
    chk("cont_mem_latency", 32'(lat), 32'd6);
    chk("cont_mem_rdata", mem_rdata, 32'hDEAD_BEEF);
    chk("cont_stall_during", {31'h0, flag}, 32'h0);
    chk("cont_stall_at_done", {31'h0, stall_o}, 32'h0);
    mem_req = 1'b0;
    lat = 0;
    while (!if_done && lat < 40) begin
      step();
      lat++;
    end
    if_req = 1'b0;
    $display("contention: if_done %0d cycles after mem_done, if_data=0x%08h", lat, if_data);
    chk("cont_if_latency", 32'(lat), 32'd6);
    chk("cont_if_data", if_data, 32'h0010_0513);
    step();

    // Fetch flush: if_req withdrawn while the third byte address is out.
    if_addr = 32'h200; if_req = 1'b1;
    step(); step(); step();
    if_req = 1'b0;
    step();
    chk("flush_ram_a_idle", ram_a, 32'h0);
    flag = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (if_done) flag = 1'b1;
      step();
    end
    $display("flush: if_done seen=%0d if_data=0x%08h", flag, if_data);
    chk("flush_no_done", {31'h0, flag}, 32'h0);
    chk("flush_if_data_hold", if_data, 32'h0010_0513);
    run_txn(1'b0, 1'b0, 2'd0, 32'h200, 32'h0, 32'hDEAD_BEEF, 4, 6, 20);

    // rdy low for three cycles in the middle of a word store.
    mem_we = 1'b1; mem_len = 2'd3; mem_addr = 32'h500; mem_wdata = 32'h5566_7788;
    mem_req = 1'b1;
    lat = 0; wr_cnt = 0; got = 1'b0;
    while (!got && lat < 40) begin
      step();
      lat++;
      rdy = (lat < 3 || lat > 5);
      #1;
      if (ram_wr) wr_cnt++;
      if (mem_done) got = 1'b1;
    end
    mem_req = 1'b0; rdy = 1'b1;
    $display("rdy stall: mem_done after %0d cycles, %0d write strobes", lat, wr_cnt);
    chk("stall_latency", 32'(lat), 32'd8);
    chk("stall_wr_count", 32'(wr_cnt), 32'd4);
    step();
    run_txn(1'b1, 1'b0, 2'd3, 32'h500, 32'h0, 32'h5566_7788, 4, 6, 21);

    // Reset asserted during the third cycle of a word load.
    mem_we = 1'b0; mem_len = 2'd3; mem_addr = 32'h300; mem_req = 1'b1;
    step(); step(); step();
    rst = 1'b1; mem_req = 1'b0;
    step();
    rst = 1'b0;
    chk("mrst_ram_a", ram_a, 32'h0);
    chk("mrst_ram_wr", {31'h0, ram_wr}, 32'h0);
    chk("mrst_ram_dout", {24'h0, ram_dout}, 32'h0);
    chk("mrst_mem_done", {31'h0, mem_done}, 32'h0);
    chk("mrst_mem_rdata", mem_rdata, 32'h0);
    chk("mrst_if_data", if_data, 32'h0);
    flag = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step();
      if (mem_done || if_done) flag = 1'b1;
    end
    $display("mid-load reset: done seen=%0d", flag);
    chk("mrst_no_done", {31'h0, flag}, 32'h0);
    run_txn(1'b1, 1'b0, 2'd3, 32'h300, 32'h0, 32'h1122_3344, 4, 6, 22);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
